// File: rtl/csrbrg_pkg.sv
// Shared definitions for the CSR bridge family: FSM state encoding and
// width helpers derived from the Wishbone data width.
package csrbrg_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RWAIT = 3'd1,
      MERGE = 3'd2,
      WRITE = 3'd3,
      ACK   = 3'd4
   } state_t;

   // Number of byte lanes in a data word.
   function automatic int sel_width(input int dw);
      return dw / 8;
   endfunction

   // Low byte-address bits dropped to form a word address.
   function automatic int word_shift(input int dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/csrbrg_merge.sv
// Byte-lane merge: each lane takes the new write byte when its select bit is
// set, otherwise keeps the byte read back from the CSR bus.
module csrbrg_merge
   import csrbrg_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0]              wr_dat,
   input  logic [DW-1:0]              rd_dat,
   input  logic [sel_width(DW)-1:0]   sel,
   output logic [DW-1:0]              merged
);

   genvar gi;
   generate
      for (gi = 0; gi < sel_width(DW); gi++) begin : g_lane
         assign merged[gi*8 +: 8] = sel[gi] ? wr_dat[gi*8 +: 8] : rd_dat[gi*8 +: 8];
      end
   endgenerate

endmodule

// File: rtl/csrbrg_rmw.sv
// Wishbone slave to CSR bus master bridge. Full-word writes go straight to the
// CSR bus; reads wait RD_LATENCY edges for csr_di; byte-select writes are done
// as read, merge, write. Dropping wb_cyc_i before the write strobe aborts.
module csrbrg_rmw
   import csrbrg_pkg::*;
#(
   parameter int CSR_AW     = 14,
   parameter int DW         = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [31:0]               wb_adr_i,
   input  logic [DW-1:0]             wb_dat_i,
   output logic [DW-1:0]             wb_dat_o,
   input  logic [sel_width(DW)-1:0]  wb_sel_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   input  logic                      wb_we_i,
   output logic                      wb_ack_o,
   output logic [CSR_AW-1:0]         csr_a,
   output logic                      csr_we,
   output logic [DW-1:0]             csr_do,
   input  logic [DW-1:0]             csr_di
);

   localparam int WS = word_shift(DW);

   state_t              state_reg, state_next;
   logic [2:0]          cnt_reg, cnt_next;
   logic                is_wr_reg, is_wr_next;
   logic [CSR_AW-1:0]   csr_a_reg, csr_a_next;
   logic [DW-1:0]       csr_do_reg, csr_do_next;
   logic                csr_we_reg, csr_we_next;
   logic                ack_reg, ack_next;
   logic [DW-1:0]       dat_reg, dat_next;
   logic [DW-1:0]       merged;
   logic                full_sel;

   // Only the word-address slice of the byte address is decoded.
   logic unused_adr;
   assign unused_adr = ^wb_adr_i;

   assign full_sel = &wb_sel_i;

   csrbrg_merge #(.DW(DW)) u_merge (
      .wr_dat (wb_dat_i),
      .rd_dat (csr_di),
      .sel    (wb_sel_i),
      .merged (merged)
   );

   // State and output registers; reset drops any in-flight transfer.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= 3'd0;
         is_wr_reg  <= 1'b0;
         csr_a_reg  <= '0;
         csr_do_reg <= '0;
         csr_we_reg <= 1'b0;
         ack_reg    <= 1'b0;
         dat_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         is_wr_reg  <= is_wr_next;
         csr_a_reg  <= csr_a_next;
         csr_do_reg <= csr_do_next;
         csr_we_reg <= csr_we_next;
         ack_reg    <= ack_next;
         dat_reg    <= dat_next;
      end
   end

   // Next-state logic; csr_we and ack are single-cycle so they default low.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      is_wr_next  = is_wr_reg;
      csr_a_next  = csr_a_reg;
      csr_do_next = csr_do_reg;
      csr_we_next = 1'b0;
      ack_next    = 1'b0;
      dat_next    = dat_reg;
      case (state_reg)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               csr_a_next = wb_adr_i[CSR_AW+WS-1:WS];
               is_wr_next = wb_we_i;
               if (wb_we_i && full_sel) begin
                  csr_do_next = wb_dat_i;
                  csr_we_next = 1'b1;
                  state_next  = WRITE;
               end else begin
                  cnt_next   = 3'(RD_LATENCY);
                  state_next = RWAIT;
               end
            end
         end
         RWAIT: begin
            if (!wb_cyc_i) begin
               cnt_next   = 3'd0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - 3'd1;
               if (cnt_reg == 3'd1) begin
                  if (is_wr_reg) begin
                     state_next = MERGE;
                  end else begin
                     dat_next   = csr_di;
                     ack_next   = 1'b1;
                     state_next = ACK;
                  end
               end
            end
         end
         MERGE: begin
            if (!wb_cyc_i) begin
               state_next = IDLE;
            end else begin
               csr_do_next = merged;
               csr_we_next = 1'b1;
               state_next  = WRITE;
            end
         end
         WRITE: begin
            // Strobe already issued: the write is committed, ack regardless.
            ack_next   = 1'b1;
            state_next = ACK;
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign wb_dat_o = dat_reg;
   assign wb_ack_o = ack_reg;
   assign csr_a    = csr_a_reg;
   assign csr_we   = csr_we_reg;
   assign csr_do   = csr_do_reg;

endmodule

// File: doc/csrbrg_rmw.md
Name: csrbrg_rmw

Overview:
- Parametrised successor of the Wishbone-to-CSR bridge.
- Wishbone slave on the system bus; single CSR bus master driving every core's CSR block.
- Adds configurable data width, CSR address width and CSR read latency.
- Adds byte-select writes, done as an internal read-modify-write on the CSR bus; adds clean abort when wb_cyc_i drops.

Parameters:
- CSR_AW, 14, CSR word-address width.
- DW, 32, data width; multiple of 8, 8..64.
- RD_LATENCY, 1, clock edges from csr_a valid to csr_di valid; range 1..7.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  DW  write data.
- wb_dat_o  out  DW  read data; valid while wb_ack_o=1.
- wb_sel_i  in  DW/8  byte enables.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  single-cycle acknowledge.
- csr_a  out  CSR_AW  CSR word address = wb_adr_i[CSR_AW+log2(DW/8)-1 : log2(DW/8)]; for defaults, adr[15:2].
- csr_we  out  1  CSR write strobe, one-cycle pulse.
- csr_do  out  DW  CSR write data.
- csr_di  in  DW  OR-combined CSR read data; unselected slaves drive 0.

Behaviour:
- Reset (async, any time, including mid-transaction): wb_ack_o=0, wb_dat_o=0, csr_a=0, csr_we=0, csr_do=0, state=IDLE, counter=0. Any in-flight transaction is dropped with no ack.
- States: IDLE, RWAIT, MERGE, WRITE, ACK. Latency counter is 3 bits.
- IDLE, on wb_cyc_i & wb_stb_i at edge E0:
  - Register csr_a from the address.
  - Write with wb_sel_i all ones: csr_do<=wb_dat_i, csr_we<=1, go WRITE.
  - Read, or write with any sel bit 0: counter<=RD_LATENCY, go RWAIT; csr_we stays 0.
- WRITE: next edge csr_we<=0, wb_ack_o<=1, go ACK. Full-write ack is high after E1.
- RWAIT: decrement each edge. When counter reaches 0 (edge E(RD_LATENCY)):
  - Read: capture wb_dat_o<=csr_di, wb_ack_o<=1, go ACK. Read ack is high after E(RD_LATENCY).
  - Partial write: go MERGE.
- MERGE: per byte b, csr_do[b] = wb_sel_i[b] ? wb_dat_i[b] : csr_di[b]; csr_we<=1; go WRITE. Partial-write ack is high after E(RD_LATENCY+2).
- wb_sel_i=0 on a write: reads and writes back unchanged data; still acked.
- ACK: wb_ack_o<=0 at next edge; return to IDLE.
  - stb is ignored during the ack cycle, so a held stb never retriggers.
  - Back-to-back transfers are accepted from the following IDLE cycle.
- csr_a and csr_do hold their values until the next transaction. wb_dat_o holds until the next read capture.
- Abort: wb_cyc_i=0 sampled in RWAIT or MERGE returns to IDLE with no ack and no csr_we.
  - Once csr_we has pulsed, the write is committed. The ack is still issued and the master ignores it.
- Reads never assert csr_we. csr_we is high for exactly one cycle per write transfer.

Decomposition:
- Package csrbrg_pkg holds:
  - State enum constants: IDLE=0, RWAIT=1, MERGE=2, WRITE=3, ACK=4.
  - Function sel_width(DW) = DW/8.
  - Function word_shift(DW) = log2(DW/8).
- Sub-module csrbrg_merge: parametrised byte-lane merge (wb_dat_i, csr_di, wb_sel_i -> merged word). Combinational; reused by future RMW bridges.
- Top module holds the FSM, counter and registers.

Test Plan:
- Bench CSR slave is registered, has RD_LATENCY latency, and is selected when csr_a[13:10]==4'ha. All scenarios use defaults unless stated.
1. Full write 0x0000a000=0xcafebabe, sel=4'hf -> csr_a=0x2800, csr_we high exactly 1 cycle with csr_do=0xcafebabe, ack after E1; slave csr1=0xcafebabe.
2. Read 0x0000a000 after test 1 -> no csr_we, ack after E1, wb_dat_o=0xcafebabe. Read 0x0000a004 after writing 0xabadface -> 0xabadface.
3. Partial write 0x0000a004, dat=0x00001234, sel=4'b0011, csr2=0xabadface -> single csr_we pulse with csr_do=0xabad1234, ack after E3; readback 0xabad1234.
4. Read unselected 0x00000010 -> wb_dat_o=0; ack after E1.
5. RD_LATENCY=3, DW=64: read -> ack after E3. Partial write, sel=8'h80 -> only the top byte changes; ack after E5.
6. Drop wb_cyc_i during RWAIT of a partial write -> no csr_we, no ack; next full write works normally.
7. Assert sys_rst while WRITE is active -> csr_we and wb_ack_o go 0 immediately, without waiting for a clock edge.
